// File: rtl/me_block_scheduler_if.sv
// Bundle of job-control, loader, motion-estimator and result-stream signals for
// the block scheduler. The scheduler sits on the master side.
interface me_block_scheduler_if;
    logic        go;
    logic [7:0]  num_blocks;
    logic        abort;
    logic        ld_req;
    logic        ld_ack;
    logic [7:0]  mb_index;
    logic        me_start;
    logic [7:0]  me_bestdist;
    logic [3:0]  me_motionx;
    logic [3:0]  me_motiony;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_data;
    logic        busy;
    logic        done;

    modport master (
        input  go, num_blocks, abort, ld_ack, me_bestdist, me_motionx, me_motiony, res_ready,
        output ld_req, mb_index, me_start, res_valid, res_data, busy, done
    );

    modport slave (
        output go, num_blocks, abort, ld_ack, me_bestdist, me_motionx, me_motiony, res_ready,
        input  ld_req, mb_index, me_start, res_valid, res_data, busy, done
    );
endinterface

// File: rtl/me_block_scheduler.sv
// Sequences load / search / settle / store for each macroblock of a job and
// queues the motion-estimator results in a small FIFO for the consumer.
module me_block_scheduler #(
    parameter int SEARCH_CYCLES = 4112,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    me_block_scheduler_if.master bus
);
    localparam int CNT_W   = $clog2(SEARCH_CYCLES + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCOUNTW = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, SETTLE, STORE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         mb_q, mb_d;
    logic [7:0]         nblk_q, nblk_d;
    logic               done_q, done_d;
    logic [23:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [FCOUNTW-1:0] count_q;
    logic               push, pop, full, empty;
    logic [23:0]        entry;

    assign empty = (count_q == '0);
    assign full  = (count_q == FCOUNTW'(FIFO_DEPTH));
    assign pop   = !empty && bus.res_ready;
    assign entry = {mb_q, bus.me_bestdist, bus.me_motiony, bus.me_motionx};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mb_d    = mb_q;
        nblk_d  = nblk_q;
        done_d  = 1'b0;
        push    = 1'b0;
        // abort outranks every other transition, including a pending push
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.go && !bus.abort) begin
                        if (bus.num_blocks != 8'd0) begin
                            nblk_d  = bus.num_blocks;
                            mb_d    = 8'd0;
                            state_d = LOAD;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.ld_ack) begin
                        cnt_d   = '0;
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    if (cnt_q == CNT_W'(SEARCH_CYCLES - 1)) begin
                        state_d = SETTLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SETTLE: state_d = STORE;
                STORE: begin
                    // a full FIFO still accepts the push when the head leaves this cycle
                    if (!full || pop) begin
                        push = 1'b1;
                        if (mb_q == nblk_q - 8'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            mb_d    = mb_q + 8'd1;
                            state_d = LOAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mb_q    <= 8'd0;
            nblk_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mb_q    <= mb_d;
            nblk_q  <= nblk_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= entry;
    end

    assign bus.ld_req    = (state_q == LOAD);
    assign bus.me_start  = (state_q == SEARCH);
    assign bus.mb_index  = mb_q;
    assign bus.res_valid = !empty;
    assign bus.res_data  = empty ? 24'd0 : mem_q[rd_q];
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_me_block_scheduler.sv
// Directed bench for me_block_scheduler: a loader/ME model queues the expected
// result of each block, and a monitor compares every popped result in order.
module tb_me_block_scheduler;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [23:0] expQ[$];
    logic [23:0] expTable [8];
    int ackDelay  = 2;
    int loadCount = 0;
    int jobBase   = 0;

    int doneCnt = 0, popCount = 0, ldCycles = 0;
    int meRun = 0, lastRun = 0, cyc = 0, meFallCyc = 0, validRiseCyc = 0;
    logic prevValid = 1'b0;
    int doneBase, popBase, ldBase, k;
    logic alive;
    logic [23:0] cur;

    me_block_scheduler_if bus ();

    me_block_scheduler #(.SEARCH_CYCLES(4112), .FIFO_DEPTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic goV, input logic abortV, input logic [7:0] nb);
        @(posedge clock);
        #1;
        bus.go         = goV;
        bus.abort      = abortV;
        bus.num_blocks = nb;
        @(posedge clock);
        #1;
        bus.go    = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic setReady(input logic v);
        @(posedge clock);
        #1;
        bus.res_ready = v;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, {31'd0, bus.done}, 32'd1);
    endtask

    initial begin
        expTable[0] = 24'h00003D;
        expTable[1] = 24'h01A512;
        expTable[2] = 24'h0207F8;
        expTable[3] = 24'h03FF77;
        expTable[4] = 24'h045A0C;
        expTable[5] = 24'h0533E1;
        expTable[6] = 24'h0680C4;
        expTable[7] = 24'h07119B;

        bus.go = 1'b0;  bus.abort = 1'b0;  bus.num_blocks = 8'd0;
        bus.ld_ack = 1'b0;  bus.res_ready = 1'b0;
        bus.me_bestdist = 8'd0;  bus.me_motionx = 4'd0;  bus.me_motiony = 4'd0;

        fork
            begin : monitor
                forever begin
                    @(negedge clock);
                    cyc++;
                    if (bus.done === 1'b1) doneCnt++;
                    if (bus.ld_req === 1'b1) ldCycles++;
                    if (bus.me_start === 1'b1) begin
                        meRun++;
                    end else if (meRun != 0) begin
                        lastRun   = meRun;
                        meRun     = 0;
                        meFallCyc = cyc;
                    end
                    if (bus.res_valid === 1'b1 && !prevValid) validRiseCyc = cyc;
                    prevValid = (bus.res_valid === 1'b1);
                    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                        popCount++;
                        if (expQ.size() == 0) begin
                            total++;
                            bad++;
                            $display("[TB] FAIL sb_unexpected: got 0x%0h, expected no result", bus.res_data);
                        end else begin
                            checkOutput("sb_res_data", {8'd0, bus.res_data}, {8'd0, expQ.pop_front()});
                        end
                    end
                end
            end
            begin : loader
                forever begin
                    @(negedge clock);
                    if (reset_n && bus.ld_req === 1'b1) begin
                        alive = 1'b1;
                        for (int i = 0; i < ackDelay - 1; i++) begin
                            @(negedge clock);
                            if (bus.ld_req !== 1'b1) alive = 1'b0;
                        end
                        if (alive) begin
                            cur = expTable[(loadCount - jobBase) & 7];
                            bus.me_bestdist = cur[15:8];
                            bus.me_motiony  = cur[7:4];
                            bus.me_motionx  = cur[3:0];
                            expQ.push_back(cur);
                            loadCount++;
                            bus.ld_ack = 1'b1;
                            @(negedge clock);
                            bus.ld_ack = 1'b0;
                        end
                    end
                end
            end
        join_none

        // reset state
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_ld_req",    {31'd0, bus.ld_req},    32'd0);
        checkOutput("rst_me_start",  {31'd0, bus.me_start},  32'd0);
        checkOutput("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        checkOutput("rst_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("rst_done",      {31'd0, bus.done},      32'd0);
        checkOutput("rst_mb_index",  {24'd0, bus.mb_index},  32'd0);
        checkOutput("rst_res_data",  {8'd0, bus.res_data},   32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // single block, ack three cycles after request
        $display("[TB] single block job");
        setReady(1'b1);
        ldBase = ldCycles;  doneBase = doneCnt;  popBase = popCount;
        jobBase = loadCount;  ackDelay = 3;
        applyStimulus(1'b1, 1'b0, 8'd1);
        waitDone("t1_done", 4400);
        checkOutput("t1_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clock);
        checkOutput("t1_me_cycles",  lastRun,                    32'd4112);
        checkOutput("t1_settle",     validRiseCyc - meFallCyc,   32'd2);
        checkOutput("t1_ld_cycles",  ldCycles - ldBase,          32'd3);
        checkOutput("t1_done_cnt",   doneCnt - doneBase,         32'd1);
        checkOutput("t1_pops",       popCount - popBase,         32'd1);
        checkOutput("t1_queue",      expQ.size(),                32'd0);

        // zero-length job
        $display("[TB] zero block job");
        ldBase = ldCycles;  doneBase = doneCnt;
        applyStimulus(1'b1, 1'b0, 8'd0);
        checkOutput("t2_done_pulse", {31'd0, bus.done}, 32'd1);
        checkOutput("t2_busy",       {31'd0, bus.busy}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("t2_done_low",   {31'd0, bus.done}, 32'd0);

        // go and abort together in IDLE: nothing starts
        applyStimulus(1'b1, 1'b1, 8'd3);
        checkOutput("t2b_busy", {31'd0, bus.busy}, 32'd0);
        repeat (5) @(negedge clock);
        checkOutput("t2_no_ld_req", ldCycles - ldBase, 32'd0);
        checkOutput("t2_done_cnt",  doneCnt - doneBase, 32'd1);

        // six blocks into a four-entry FIFO with the consumer stalled
        $display("[TB] fifo fill and stall");
        setReady(1'b0);
        doneBase = doneCnt;  popBase = popCount;
        jobBase = loadCount;  ackDelay = 2;
        applyStimulus(1'b1, 1'b0, 8'd6);
        k = 0;
        while ((loadCount - jobBase) < 5 && k < 30000) begin
            @(negedge clock);
            k++;
        end
        repeat (4200) @(negedge clock);
        checkOutput("t3_loads",     loadCount - jobBase,           32'd5);
        checkOutput("t3_busy",      {31'd0, bus.busy},             32'd1);
        checkOutput("t3_me_start",  {31'd0, bus.me_start},         32'd0);
        checkOutput("t3_ld_req",    {31'd0, bus.ld_req},           32'd0);
        checkOutput("t3_mb_index",  {24'd0, bus.mb_index},         32'd4);
        checkOutput("t3_res_valid", {31'd0, bus.res_valid},        32'd1);
        checkOutput("t3_head",      {8'd0, bus.res_data},          32'h00003D);
        checkOutput("t3_no_pops",   popCount - popBase,            32'd0);

        // release: full FIFO pushes and pops in the same cycle
        setReady(1'b1);
        @(posedge clock);
        #1;
        checkOutput("t4_no_stall",  {31'd0, bus.ld_req},    32'd1);
        checkOutput("t4_mb_index",  {24'd0, bus.mb_index},  32'd5);
        checkOutput("t4_res_valid", {31'd0, bus.res_valid}, 32'd1);
        checkOutput("t4_head",      {8'd0, bus.res_data},   32'h01A512);
        waitDone("t4_done", 6000);
        repeat (2) @(negedge clock);
        checkOutput("t4_done_cnt", doneCnt - doneBase,  32'd1);
        checkOutput("t4_pops",     popCount - popBase,  32'd6);
        checkOutput("t4_queue",    expQ.size(),         32'd0);

        // abort during SEARCH keeps earlier FIFO contents
        $display("[TB] abort mid search");
        setReady(1'b0);
        jobBase = loadCount;
        applyStimulus(1'b1, 1'b0, 8'd2);
        waitDone("t5_prep_done", 9000);
        repeat (2) @(negedge clock);
        doneBase = doneCnt;  popBase = popCount;
        jobBase = loadCount;
        applyStimulus(1'b1, 1'b0, 8'd3);
        k = 0;
        while (bus.me_start !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        repeat (99) @(posedge clock);
        applyStimulus(1'b0, 1'b1, 8'd0);
        checkOutput("t5_me_start",  {31'd0, bus.me_start},  32'd0);
        checkOutput("t5_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("t5_ld_req",    {31'd0, bus.ld_req},    32'd0);
        checkOutput("t5_res_valid", {31'd0, bus.res_valid}, 32'd1);
        checkOutput("t5_head",      {8'd0, bus.res_data},   32'h00003D);
        @(negedge clock);
        checkOutput("t5_search_len", lastRun,      32'd101);
        checkOutput("t5_expq",       expQ.size(),  32'd3);
        if (expQ.size() > 0) void'(expQ.pop_back());
        repeat (10) @(negedge clock);
        checkOutput("t5_no_done", doneCnt - doneBase, 32'd0);
        setReady(1'b1);
        repeat (10) @(negedge clock);
        checkOutput("t5_pops",      popCount - popBase,    32'd2);
        checkOutput("t5_queue",     expQ.size(),           32'd0);
        checkOutput("t5_empty",     {31'd0, bus.res_valid}, 32'd0);

        // asynchronous reset in the middle of a LOAD
        $display("[TB] reset mid load");
        setReady(1'b0);
        doneBase = doneCnt;  popBase = popCount;
        jobBase = loadCount;  ackDelay = 2;
        applyStimulus(1'b1, 1'b0, 8'd2);
        k = 0;
        while (bus.me_start !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        ackDelay = 30;
        k = 0;
        while (bus.ld_req !== 1'b1 && k < 5000) begin
            @(negedge clock);
            k++;
        end
        repeat (5) @(negedge clock);
        checkOutput("t6_pre_mb",    {24'd0, bus.mb_index},  32'd1);
        checkOutput("t6_pre_valid", {31'd0, bus.res_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_ld_req",    {31'd0, bus.ld_req},    32'd0);
        checkOutput("t6_me_start",  {31'd0, bus.me_start},  32'd0);
        checkOutput("t6_res_valid", {31'd0, bus.res_valid}, 32'd0);
        checkOutput("t6_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("t6_done",      {31'd0, bus.done},      32'd0);
        checkOutput("t6_mb_index",  {24'd0, bus.mb_index},  32'd0);
        checkOutput("t6_res_data",  {8'd0, bus.res_data},   32'd0);
        expQ.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        setReady(1'b1);
        jobBase = loadCount;  ackDelay = 3;
        applyStimulus(1'b1, 1'b0, 8'd1);
        waitDone("t6_new_done", 4400);
        repeat (2) @(negedge clock);
        checkOutput("t6_done_cnt", doneCnt - doneBase,  32'd1);
        checkOutput("t6_pops",     popCount - popBase,  32'd1);
        checkOutput("t6_queue",    expQ.size(),         32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
